// File: rtl/multicycle_controller_if.sv
// Handshake bundle between the multicycle control FSM and the datapath/IR/memory port.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             ir_write;
  logic             mem_write;
  logic             RegWrite_en;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [3:0]       ALUControl;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, RegWrite_en,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instret
  );

  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, RegWrite_en,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-ALU multicycle RISC-V datapath, with a retired-instruction counter.
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready=1.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_ok;
  logic             retire;
  logic [3:0]       funct_alu;

`ifdef MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECUTER;
          OP_I:              state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: if (mem_ok) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_d = S_ILLEGAL;
    endcase
    instret_d = instret_q + CNT_W'(retire);
  end

  always_comb begin
    funct_alu = ALU_ADD;
    unique case (bus.funct3)
      3'b000: funct_alu = (bus.op[5] & bus.funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: funct_alu = ALU_SLL;
      3'b010: funct_alu = ALU_SLT;
      3'b011: funct_alu = ALU_SLTU;
      3'b100: funct_alu = ALU_XOR;
      3'b101: funct_alu = bus.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: funct_alu = ALU_OR;
      3'b111: funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  // Output decode; FETCH strobes gate on mem_ok so a stalled fetch does not reload IR/PC
  always_comb begin
    bus.pc_write    = 1'b0;
    bus.adr_src     = 1'b0;
    bus.ir_write    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.RegWrite_en = 1'b0;
    bus.ResultSrc   = 2'b00;
    bus.ALUSrcA     = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.ALUControl  = ALU_ADD;
    bus.illegal     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.ir_write  = mem_ok;
        bus.pc_write  = mem_ok;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMREAD:  bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc   = 2'b01;
        bus.RegWrite_en = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = funct_alu;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = funct_alu;
      end
      S_ALUWB:    bus.RegWrite_en = 1'b1;
      S_JAL: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.pc_write = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
        bus.pc_write   = bus.zero;
      end
      default:    bus.illegal = 1'b1;
    endcase
    if (!rst_n) begin
      bus.pc_write    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.RegWrite_en = 1'b0;
    end
  end

  always_comb begin
    unique case (bus.op)
      OP_STORE: bus.ImmSrc = 2'b01;
      OP_BEQ:   bus.ImmSrc = 2'b10;
      OP_JAL:   bus.ImmSrc = 2'b11;
      default:  bus.ImmSrc = 2'b00;
    endcase
  end

  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle/strobe reference model,
// directed and randomized instruction streams; a narrow-counter instance exercises instret wrap.
module tb_multicycle_controller;
  localparam int CNT_W = 32;

  typedef enum int {C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_ILL} cls_e;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [CNT_W-1:0] exp_instret;

  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();
  multicycle_controller_if #(.CNT_W(2))     bus2 ();

  assign bus2.op        = bus.op;
  assign bus2.funct3    = bus.funct3;
  assign bus2.funct7    = bus.funct7;
  assign bus2.zero      = bus.zero;
  assign bus2.mem_ready = bus.mem_ready;

  multicycle_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_controller #(.CNT_W(2))     dut_w (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic logic [6:0] op_of(cls_e c);
    case (c)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_BEQ:   return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int latency(cls_e c);
    case (c)
      C_LW:    return 5;
      C_BEQ:   return 3;
      default: return 4;
    endcase
  endfunction

  // {pc_write, ir_write, mem_write, RegWrite_en} expected in cycle cyc of an instruction
  function automatic logic [3:0] exp_strobes(cls_e c, int cyc, logic z);
    if (cyc == 0) return 4'b1100;
    if (c == C_JAL && cyc == 2) return 4'b1000;
    if (cyc == latency(c) - 1) begin
      case (c)
        C_SW:    return 4'b0010;
        C_BEQ:   return {z, 3'b000};
        default: return 4'b0001;
      endcase
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] alu_ref(cls_e c, logic [2:0] f3, logic [6:0] f7);
    logic [3:0] tbl [8];
    logic [3:0] r;
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    r = tbl[f3];
    if (f3 == 3'd0 && c == C_R && f7[5]) r = 4'd1;
    if (f3 == 3'd5 && f7[5]) r = 4'd9;
    return r;
  endfunction

  function automatic logic [3:0] exp_alu(cls_e c, int cyc, logic [2:0] f3, logic [6:0] f7);
    if (cyc != 2) return 4'd0;
    if (c == C_R || c == C_I) return alu_ref(c, f3, f7);
    if (c == C_BEQ) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [1:0] imm_ref(cls_e c);
    case (c)
      C_SW:    return 2'b01;
      C_BEQ:   return 2'b10;
      C_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check_instret();
    n_cmp++;
    if (bus.instret !== exp_instret) begin
      n_err++;
      $display("FAIL instret got=%0d exp=%0d", bus.instret, exp_instret);
    end
    n_cmp++;
    if (bus2.instret !== exp_instret[1:0]) begin
      n_err++;
      $display("FAIL instret_wrap got=%0d exp=%0d", bus2.instret, exp_instret[1:0]);
    end
  endtask

  // Runs one legal instruction from FETCH; entered and left at #1 after a rising edge
  task automatic run_instr(input cls_e c, input logic [2:0] f3, input logic [6:0] f7, input logic z);
    logic [3:0] got_s, want_s, want_alu;
    bus.op = op_of(c); bus.funct3 = f3; bus.funct7 = f7; bus.zero = z;
    for (int cyc = 0; cyc < latency(c); cyc++) begin
      @(negedge clk);
      got_s  = {bus.pc_write, bus.ir_write, bus.mem_write, bus.RegWrite_en};
      want_s = exp_strobes(c, cyc, z);
      n_cmp++;
      if (got_s !== want_s) begin
        n_err++;
        $display("FAIL strobes cls=%0d cyc=%0d got=%b exp=%b", c, cyc, got_s, want_s);
      end
      want_alu = exp_alu(c, cyc, f3, f7);
      n_cmp++;
      if (bus.ALUControl !== want_alu) begin
        n_err++;
        $display("FAIL alu_control cls=%0d cyc=%0d f3=%0d f7=%b got=%b exp=%b", c, cyc, f3, f7, bus.ALUControl, want_alu);
      end
      n_cmp++;
      if (bus.illegal !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_low cls=%0d cyc=%0d got=%b exp=0", c, cyc, bus.illegal);
      end
      if (cyc == 0) begin
        n_cmp++;
        if ({bus.adr_src, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB} !== 7'b0_10_00_10) begin
          n_err++;
          $display("FAIL fetch_mux got=%b exp=0100010", {bus.adr_src, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB});
        end
        if (c != C_R) begin
          n_cmp++;
          if (bus.ImmSrc !== imm_ref(c)) begin
            n_err++;
            $display("FAIL imm_src cls=%0d got=%b exp=%b", c, bus.ImmSrc, imm_ref(c));
          end
        end
      end
      if ((c == C_LW || c == C_SW) && cyc == 3) begin
        n_cmp++;
        if (bus.adr_src !== 1'b1) begin
          n_err++;
          $display("FAIL adr_src_mem cls=%0d got=%b exp=1", c, bus.adr_src);
        end
      end
      if (c == C_LW && cyc == 4) begin
        n_cmp++;
        if (bus.ResultSrc !== 2'b01) begin
          n_err++;
          $display("FAIL memwb_result got=%b exp=01", bus.ResultSrc);
        end
      end
      if ((c == C_R || c == C_I) && cyc == 2) begin
        n_cmp++;
        if ({bus.ALUSrcA, bus.ALUSrcB} !== {2'b10, (c == C_I) ? 2'b01 : 2'b00}) begin
          n_err++;
          $display("FAIL exec_src cls=%0d got=%b", c, {bus.ALUSrcA, bus.ALUSrcB});
        end
      end
      @(posedge clk); #1;
    end
    exp_instret = exp_instret + 1'b1;
    check_instret();
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    bus.op = 7'b0110011; bus.funct3 = '0; bus.funct7 = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    apply_reset(2);
    @(negedge clk);
    n_cmp++;
    if ({bus.pc_write, bus.ir_write, bus.mem_write, bus.RegWrite_en, bus.illegal} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_strobes got=%b exp=00000", {bus.pc_write, bus.ir_write, bus.mem_write, bus.RegWrite_en, bus.illegal});
    end
    check_instret();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ir_write, bus.pc_write} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release_fetch got=%b exp=11", {bus.ir_write, bus.pc_write});
    end
    @(posedge clk); #1;
    apply_reset(1);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_instr(C_R, 3'b000, 7'b0000000, 1'b0);
  endtask

  task automatic test_sub_srai();
    run_instr(C_R, 3'b000, 7'b0100000, 1'b0);
    run_instr(C_I, 3'b101, 7'b0100000, 1'b0);
    run_instr(C_I, 3'b000, 7'b0100000, 1'b1);
  endtask

  task automatic test_lw_sw();
    run_instr(C_LW, 3'b010, 7'b0000000, 1'b0);
    run_instr(C_SW, 3'b010, 7'b0000000, 1'b0);
  endtask

  task automatic test_beq();
    run_instr(C_BEQ, 3'b000, 7'b0000000, 1'b1);
    run_instr(C_BEQ, 3'b000, 7'b0000000, 1'b0);
    run_instr(C_JAL, 3'b000, 7'b0000000, 1'b0);
  endtask

  task automatic test_random();
    cls_e c;
    logic [6:0] f7;
    for (int n = 0; n < 40; n++) begin
      c = cls_e'($urandom_range(0, 5));
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0100000;
        1:       f7 = 7'b0000000;
        default: f7 = 7'($urandom);
      endcase
      run_instr(c, 3'($urandom), f7, 1'($urandom));
    end
  endtask

  task automatic test_illegal();
    logic [3:0] got_s;
    bus.op = 7'b0000000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      got_s = {bus.pc_write, bus.ir_write, bus.mem_write, bus.RegWrite_en};
      n_cmp++;
      if (got_s !== ((cyc == 0) ? 4'b1100 : 4'b0000)) begin
        n_err++;
        $display("FAIL illegal_strobes cyc=%0d got=%b", cyc, got_s);
      end
      n_cmp++;
      if (bus.illegal !== (cyc >= 2)) begin
        n_err++;
        $display("FAIL illegal_flag cyc=%0d got=%b exp=%b", cyc, bus.illegal, cyc >= 2);
      end
      check_instret();
      @(posedge clk); #1;
    end
    apply_reset(1);
    n_cmp++;
    if (bus.illegal !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_recover got=%b exp=0", bus.illegal);
    end
    check_instret();
    rst_n = 1'b1;
    run_instr(C_R, 3'b110, 7'b0000000, 1'b0);
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    bus.op = 7'b0110011; bus.funct3 = '0; bus.funct7 = '0;
    bus.mem_ready = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.ir_write, bus.pc_write} !== 2'b00) begin
        n_err++;
        $display("FAIL wait_fetch cyc=%0d got=%b exp=00", cyc, {bus.ir_write, bus.pc_write});
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    run_instr(C_R, 3'b000, 7'b0000000, 1'b0);
  endtask
`endif

  initial begin
    exp_instret = '0;
    rst_n = 1'b0;
    test_reset();
    test_add();
    test_sub_srai();
    test_lw_sw();
    test_beq();
    test_random();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
